// File: rtl/circuit_sweep_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sweep_pkg
// Purpose : Shared types and helpers for the circuit sweep driver. Holds the
//           sweep FSM state encoding, the weight-order vector table and the
//           seq() helper that maps a sweep step to the vector driven on stim.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_t;

  // Weight order 0,1,2,4,3,6,5,7 packed 3 bits per entry, step 0 in the LSBs.
  localparam logic [23:0] C_WEIGHT_TBL = {3'd7, 3'd5, 3'd6, 3'd3,
                                          3'd4, 3'd2, 3'd1, 3'd0};

  // Vector driven for sweep step idx. order 1 is only legal for 3-input
  // sweeps, so the table lookup only needs the low three index bits.
  function automatic logic [31:0] seq(input logic [31:0] idx, input int order);
    logic [31:0] v;
    if (order == 1) begin
      v = {29'd0, C_WEIGHT_TBL[idx[2:0]*3 +: 3]};
    end else begin
      v = idx;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/circuit_sweep_driver_if.sv
`default_nettype none
// ============================================================================
// Module  : circuit_sweep_driver_if
// Purpose : Bundle of sweep control, circuit drive/response and result signals.
//           slave modport is the sweep driver, master is its controller.
//           Optional macro SWEEP_CHECK_EN adds expected_map / mismatch.
// Ports   : start, resp, stim, step_idx, busy, done, result_valid,
//           result_map [, expected_map, mismatch]
// Revision: 1.0 - initial release
// ============================================================================
interface circuit_sweep_driver_if #(
  parameter int NUM_IN = 3
);
  logic                   start;
  logic                   resp;
  logic [NUM_IN-1:0]      stim;
  logic [NUM_IN-1:0]      step_idx;
  logic                   busy;
  logic                   done;
  logic                   result_valid;
  logic [2**NUM_IN-1:0]   result_map;
`ifdef SWEEP_CHECK_EN
  logic [2**NUM_IN-1:0]   expected_map;
  logic                   mismatch;
`endif

  modport master (
    output start,
    output resp,
`ifdef SWEEP_CHECK_EN
    output expected_map,
    input  mismatch,
`endif
    input  stim,
    input  step_idx,
    input  busy,
    input  done,
    input  result_valid,
    input  result_map
  );

  modport slave (
    input  start,
    input  resp,
`ifdef SWEEP_CHECK_EN
    input  expected_map,
    output mismatch,
`endif
    output stim,
    output step_idx,
    output busy,
    output done,
    output result_valid,
    output result_map
  );

endinterface
`default_nettype wire

// File: rtl/circuit_sweep_driver_hold_timer.sv
`default_nettype none
// ============================================================================
// Module  : sweep_hold_timer
// Purpose : Hold-window counter. Cleared by i_load, counts while i_en, and
//           pulses o_tc on the last clock of each HOLD_CYCLES window, wrapping
//           back to zero on that same edge.
// Ports   : clk, rst (sync, active-high), i_load, i_en, o_tc
// Revision: 1.0 - initial release
// ============================================================================
module sweep_hold_timer #(
  parameter int HOLD_CYCLES = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int              C_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [C_W-1:0]  C_LAST = C_W'(HOLD_CYCLES - 1);

  logic [C_W-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/circuit_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module  : circuit_sweep_driver
// Purpose : Walks stim through every input vector of a small combinational
//           circuit, holding each for HOLD_CYCLES clocks, and captures resp at
//           the end of each window into a truth-table bitmap (result_map,
//           indexed by vector value).
// Ports   : clk, rst (sync, active-high), bus (circuit_sweep_driver_if.slave:
//           start, resp, stim, step_idx, busy, done, result_valid, result_map)
// Options : define SWEEP_CHECK_EN to add expected_map input and mismatch flag.
// Revision: 1.0 - initial release
// ============================================================================
module circuit_sweep_driver
  import sweep_pkg::*;
#(
  parameter int NUM_IN      = 3,
  parameter int HOLD_CYCLES = 7,
  parameter int ORDER       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  circuit_sweep_driver_if.slave   bus
);

  localparam int                C_NVEC      = 2**NUM_IN;
  localparam logic [NUM_IN-1:0] C_LAST_STEP = NUM_IN'(C_NVEC - 1);

  // Elaboration-time parameter checks.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("circuit_sweep_driver: HOLD_CYCLES must be >= 1");
  end
  if ((ORDER != 0) && (ORDER != 1)) begin : g_bad_order
    $error("circuit_sweep_driver: ORDER must be 0 or 1");
  end
  if ((ORDER == 1) && (NUM_IN != 3)) begin : g_bad_order_width
    $error("circuit_sweep_driver: ORDER=1 requires NUM_IN==3");
  end

  sweep_state_t        r_state;
  logic [NUM_IN-1:0]   r_stim;
  logic [NUM_IN-1:0]   r_step_idx;
  logic                r_busy;
  logic                r_done;
  logic                r_result_valid;
  logic [C_NVEC-1:0]   r_result_map;
  logic                w_accept;
  logic                w_run;
  logic                w_tc;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_run    = (r_state == ST_RUN);

  sweep_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_en   (w_run),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_stim         <= '0;
      r_step_idx     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_map   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state        <= ST_RUN;
            r_step_idx     <= '0;
            r_stim         <= NUM_IN'(seq(32'd0, ORDER));
            r_result_map   <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_tc) begin
            // Indexed by the vector value, not the step number.
            r_result_map[r_stim] <= bus.resp;
            if (r_step_idx == C_LAST_STEP) begin
              r_state    <= ST_DONE;
              r_stim     <= '0;
              r_step_idx <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_step_idx <= r_step_idx + 1'b1;
              r_stim     <= NUM_IN'(seq(32'(r_step_idx) + 32'd1, ORDER));
            end
          end
        end
        ST_DONE: begin
          r_done         <= 1'b0;
          r_result_valid <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SWEEP_CHECK_EN
  logic r_mismatch;

  // Evaluated in DONE, by which point result_map already holds the last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mismatch <= 1'b0;
    end else if (w_accept) begin
      r_mismatch <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_mismatch <= |(r_result_map ^ bus.expected_map);
    end
  end

  assign bus.mismatch = r_mismatch;
`endif

  assign bus.stim         = r_stim;
  assign bus.step_idx     = r_step_idx;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result_valid = r_result_valid;
  assign bus.result_map   = r_result_map;

endmodule
`default_nettype wire

// File: tb/tb_circuit_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_circuit_sweep_driver
// Purpose : Self-checking bench for circuit_sweep_driver. Three instances:
//           ORDER=0/HOLD=7, ORDER=1/HOLD=7, ORDER=0/HOLD=1. Each circuit under
//           drive is a truth table held by the bench (resp = table[stim]).
// Revision: 1.0 - initial release
// ============================================================================
module tb_circuit_sweep_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  circuit_sweep_driver_if #(.NUM_IN(3)) if0 ();
  circuit_sweep_driver_if #(.NUM_IN(3)) if1 ();
  circuit_sweep_driver_if #(.NUM_IN(3)) if2 ();

  circuit_sweep_driver #(.NUM_IN(3), .HOLD_CYCLES(7), .ORDER(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave));
  circuit_sweep_driver #(.NUM_IN(3), .HOLD_CYCLES(7), .ORDER(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave));
  circuit_sweep_driver #(.NUM_IN(3), .HOLD_CYCLES(1), .ORDER(0)) u_dut2 (
    .clk (clk), .rst (rst), .bus (if2.slave));

  logic [2:0] start_v;
  logic [7:0] tt [3];

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.resp  = tt[0][if0.stim];
  assign if1.resp  = tt[1][if1.stim];
  assign if2.resp  = tt[2][if2.stim];

  logic [2:0] o_stim [3];
  logic [2:0] o_step [3];
  logic       o_busy [3];
  logic       o_done [3];
  logic       o_rv   [3];
  logic [7:0] o_map  [3];

  assign o_stim[0] = if0.stim;     assign o_stim[1] = if1.stim;     assign o_stim[2] = if2.stim;
  assign o_step[0] = if0.step_idx; assign o_step[1] = if1.step_idx; assign o_step[2] = if2.step_idx;
  assign o_busy[0] = if0.busy;     assign o_busy[1] = if1.busy;     assign o_busy[2] = if2.busy;
  assign o_done[0] = if0.done;     assign o_done[1] = if1.done;     assign o_done[2] = if2.done;
  assign o_rv[0]   = if0.result_valid; assign o_rv[1] = if1.result_valid; assign o_rv[2] = if2.result_valid;
  assign o_map[0]  = if0.result_map;   assign o_map[1] = if1.result_map;   assign o_map[2] = if2.result_map;

`ifdef SWEEP_CHECK_EN
  logic [7:0] exp0;
  assign if0.expected_map = exp0;
  assign if1.expected_map = 8'h00;
  assign if2.expected_map = 8'h00;
  logic o_mm [3];
  assign o_mm[0] = if0.mismatch; assign o_mm[1] = if1.mismatch; assign o_mm[2] = if2.mismatch;
`endif

  // Reference: per-instance configuration and the vector for each step.
  int hold_of [3] = '{7, 7, 1};
  int ord_of  [3] = '{0, 1, 0};
  int wt      [8] = '{0, 1, 2, 4, 3, 6, 5, 7};

  function automatic int model_vec(int ord, int step);
    return (ord == 1) ? wt[step] : step;
  endfunction

  int nchk = 0;
  int nfail = 0;

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_idle_reset(int k);
    check("rst_stim", k, 32'(o_stim[k]), 32'd0);
    check("rst_step", k, 32'(o_step[k]), 32'd0);
    check("rst_busy", k, 32'(o_busy[k]), 32'd0);
    check("rst_done", k, 32'(o_done[k]), 32'd0);
    check("rst_rv",   k, 32'(o_rv[k]),   32'd0);
    check("rst_map",  k, 32'(o_map[k]),  32'd0);
`ifdef SWEEP_CHECK_EN
    check("rst_mismatch", k, 32'(o_mm[k]), 32'd0);
`endif
  endtask

  // Full sweep on instance k with truth table t. Entered and left on a
  // negedge. keep_start holds start high through RUN and the DONE cycle.
  task automatic sweep(int k, logic [7:0] t, bit keep_start);
    int n;
    n = 8 * hold_of[k];
    tt[k] = t;
    start_v[k] = 1'b1;
    @(negedge clk);
    if (!keep_start) start_v[k] = 1'b0;
    for (int c = 0; c < n; c++) begin
      check("stim", k, 32'(o_stim[k]), 32'(model_vec(ord_of[k], c / hold_of[k])));
      check("step", k, 32'(o_step[k]), 32'(c / hold_of[k]));
      check("busy", k, 32'(o_busy[k]), 32'd1);
      check("done_early", k, 32'(o_done[k]), 32'd0);
      if (c == 0) begin
        check("rv_cleared", k, 32'(o_rv[k]), 32'd0);
`ifdef SWEEP_CHECK_EN
        check("mismatch_cleared", k, 32'(o_mm[k]), 32'd0);
`endif
      end
      @(negedge clk);
    end
    check("done_pulse", k, 32'(o_done[k]), 32'd1);
    check("done_busy",  k, 32'(o_busy[k]), 32'd0);
    check("done_stim",  k, 32'(o_stim[k]), 32'd0);
    check("done_step",  k, 32'(o_step[k]), 32'd0);
    @(negedge clk);
    start_v[k] = 1'b0;
    check("done_one_cycle", k, 32'(o_done[k]), 32'd0);
    check("result_valid",   k, 32'(o_rv[k]),   32'd1);
    check("result_map",     k, 32'(o_map[k]),  32'(t));
    check("idle_busy",      k, 32'(o_busy[k]), 32'd0);
`ifdef SWEEP_CHECK_EN
    if (k == 0) check("mismatch", k, 32'(o_mm[k]), 32'(|(t ^ exp0)));
`endif
    @(negedge clk);
    check("no_restart", k, 32'(o_busy[k]), 32'd0);
    check("rv_held",    k, 32'(o_rv[k]),   32'd1);
  endtask

  initial begin
    logic [7:0] parity;
    bit         saw_done;
    parity  = 8'b1001_0110;
    rst     = 1'b1;
    start_v = 3'b000;
    tt[0] = 8'h00; tt[1] = 8'h00; tt[2] = 8'h00;
`ifdef SWEEP_CHECK_EN
    exp0 = 8'h00;
`endif
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_idle_reset(k);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_idle_reset(k);

    // Binary order, parity circuit, then random circuits.
    sweep(0, parity, 1'b0);
    sweep(0, 8'($urandom()), 1'b0);

    // Weight order, AND of the two upper inputs, then random.
    sweep(1, 8'b1100_0000, 1'b0);
    sweep(1, 8'($urandom()), 1'b0);

    // Single-cycle hold.
    sweep(2, 8'b1010_1010, 1'b0);
    repeat (2) sweep(2, 8'($urandom()), 1'b0);

    // start held through RUN and DONE: exactly one sweep.
    sweep(0, 8'($urandom()), 1'b1);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy[0] || o_done[0]) saw_done = 1'b1;
    end
    check("held_start_no_rerun", 0, 32'(saw_done), 32'd0);

    // Reset in the middle of step 3.
    tt[0] = parity;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (22) @(negedge clk);
    check("mid_step", 0, 32'(o_step[0]), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_reset(0);
    saw_done = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (o_done[0] || o_busy[0]) saw_done = 1'b1;
    end
    check("abort_no_done", 0, 32'(saw_done), 32'd0);
    sweep(0, parity, 1'b0);

`ifdef SWEEP_CHECK_EN
    exp0 = parity;
    sweep(0, parity, 1'b0);
    sweep(0, parity ^ 8'h20, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire
